// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port: IF fetch port, D data port and memory side.
// slave is the arbiter's view; master is the requesters-plus-memory environment.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          if_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          d_stall;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          timeout;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, timeout
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the IF (fetch) and D (load/store) pipeline stages.
// One transaction in flight; D has priority but yields to IF after MAX_DSTREAK grants.
module mem_port_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mem_port_arbiter_if.slave    io_bus
);
    localparam int SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_D  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [SW-1:0] r_streak;
    logic [WW-1:0] r_wait;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_we;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_if_ready;
    logic          r_d_ready;
    logic          r_timeout;

    logic          w_if_elig;
    logic          w_d_elig;
    logic          w_streak_ok;
    logic          w_wait_hit;
    logic          w_grant_if;
    logic          w_grant_d;
    logic          w_if_fin;
    logic          w_d_fin;
    logic          w_abort;
    logic          w_busy;

    // A port whose ready pulse is showing is still dropping its req; don't re-grant it.
    assign w_if_elig   = io_bus.if_req & ~r_if_ready;
    assign w_d_elig    = io_bus.d_req  & ~r_d_ready;
    assign w_streak_ok = (r_streak < SW'(MAX_DSTREAK));
    assign w_wait_hit  = (TIMEOUT != 0) && (r_wait == WW'(TIMEOUT - 1));
    assign w_busy      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_d   = 1'b0;
        w_if_fin    = 1'b0;
        w_d_fin     = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_d_elig && (!w_if_elig || w_streak_ok)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY_D;
                end else if (w_if_elig) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = S_BUSY_IF;
                end
            end
            S_BUSY_IF: begin
                if (io_bus.mem_ack || w_wait_hit) begin
                    w_if_fin    = 1'b1;
                    w_abort     = ~io_bus.mem_ack;
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY_D: begin
                if (io_bus.mem_ack || w_wait_hit) begin
                    w_d_fin     = 1'b1;
                    w_abort     = ~io_bus.mem_ack;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_streak   <= '0;
            r_wait     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_if_ready <= w_if_fin;
            r_d_ready  <= w_d_fin;
            r_timeout  <= w_abort;

            if (w_grant_d) begin
                r_addr  <= io_bus.d_addr;
                r_we    <= io_bus.d_we;
                r_wdata <= io_bus.d_wdata;
            end else if (w_grant_if) begin
                r_addr  <= io_bus.if_addr;
                r_we    <= 1'b0;
            end

            if (w_grant_d || w_grant_if) begin
                r_wait <= '0;
            end else if (w_busy && !(&r_wait)) begin
                r_wait <= r_wait + WW'(1);
            end

            // Streak only grows while IF is actually being held off.
            if (w_grant_d) begin
                if (w_if_elig) begin
                    if (w_streak_ok) r_streak <= r_streak + SW'(1);
                end else begin
                    r_streak <= '0;
                end
            end else if (w_grant_if) begin
                r_streak <= '0;
            end

            if (w_if_fin && io_bus.mem_ack) begin
                r_if_rdata <= io_bus.mem_rdata;
            end
            if (w_d_fin && io_bus.mem_ack && !r_we) begin
                r_d_rdata <= io_bus.mem_rdata;
            end
        end
    end

    assign io_bus.if_rdata  = r_if_rdata;
    assign io_bus.if_ready  = r_if_ready;
    assign io_bus.if_stall  = io_bus.if_req & ~r_if_ready;
    assign io_bus.d_rdata   = r_d_rdata;
    assign io_bus.d_ready   = r_d_ready;
    assign io_bus.d_stall   = io_bus.d_req & ~r_d_ready;
    assign io_bus.mem_en    = w_busy;
    assign io_bus.mem_we    = r_we & (r_state == S_BUSY_D);
    assign io_bus.mem_addr  = r_addr;
    assign io_bus.mem_wdata = r_wdata;
    assign io_bus.timeout   = r_timeout;
endmodule
